pipe_stall_ctrl: RTL

Pipeline sequencing controller for the 5-stage core. It turns the hazard unit's load-use flag, the EX-stage branch resolution and the multi-cycle (MUL/DIV) unit handshake into per-stage register enables and flushes. It owns the PC, IF/DE, DE/EX and EX/MEM advance decisions. MEM/WB always advances.

---
 rtl/pipe_stall_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: turns load-use, taken-branch and multi-cycle-op events into per-stage enables/flushes.
// Latency: Mealy outputs, combinational from state and current inputs; state updates on the next clk edge.
// Backpressure: holds the front end while a multi-cycle op waits for mc_done. Optional macro: PIPE_STALL_PERF_CNT_EN.
module pipe_stall_ctrl #(
  parameter int LU_STALL_CYC = 1,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_load_use,
  input  logic             br_taken_ex,
  input  logic             mc_op_ex,
  input  logic             mc_done,
  output logic             mc_go,
  output logic             pc_en,
  output logic             ifde_en,
  output logic             deex_en,
  output logic             exmem_en,
  output logic             ifde_flush,
  output logic             deex_flush,
  output logic             exmem_flush,
  output logic             mc_err,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_LU  = 2'd1;
  localparam logic [1:0] ST_MC  = 2'd2;

  // The timeout counter only ever has to reach MC_TIMEOUT-1 before the forced release.
  localparam int              TO_W    = $clog2(MC_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      lu_q, lu_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q;
  logic            err_set;

  // Next-state and Mealy output decode; reset forces every stage to hold a bubble.
  always_comb begin
    mc_go       = 1'b0;
    pc_en       = 1'b1;
    ifde_en     = 1'b1;
    deex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifde_flush  = 1'b0;
    deex_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_d     = state_q;
    lu_d        = lu_q;
    to_d        = to_q;
    err_set     = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifde_en     = 1'b0;
      deex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifde_flush  = 1'b1;
      deex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mc_op_ex) begin
            // Start the unit and freeze everything upstream of EX.
            mc_go       = 1'b1;
            pc_en       = 1'b0;
            ifde_en     = 1'b0;
            deex_en     = 1'b0;
            exmem_flush = 1'b1;
            state_d     = ST_MC;
            to_d        = '0;
          end else if (br_taken_ex) begin
            // PC takes the target; the two wrong-path instructions become bubbles.
            ifde_flush = 1'b1;
            deex_flush = 1'b1;
          end else if (hz_load_use) begin
            pc_en      = 1'b0;
            ifde_en    = 1'b0;
            deex_flush = 1'b1;
            if (LU_STALL_CYC > 1) begin
              state_d = ST_LU;
              lu_d    = 2'(LU_STALL_CYC - 1);
            end
          end
        end
        ST_LU: begin
          pc_en      = 1'b0;
          ifde_en    = 1'b0;
          deex_flush = 1'b1;
          if (br_taken_ex) begin
            ifde_flush = 1'b1;
          end
          lu_d = lu_q - 2'd1;
          if (lu_q <= 2'd1) begin
            state_d = ST_RUN;
          end
        end
        ST_MC: begin
          if (mc_done || (to_q == TO_LAST)) begin
            // Release: EX/MEM captures the result, front end resumes.
            state_d = ST_RUN;
            err_set = ~mc_done;
          end else begin
            pc_en       = 1'b0;
            ifde_en     = 1'b0;
            deex_en     = 1'b0;
            exmem_flush = 1'b1;
            to_d        = to_q + 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State, stall counters and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      lu_q    <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lu_q    <= lu_d;
      to_q    <= to_d;
      err_q   <= err_q | err_set;
    end
  end

  assign mc_err    = err_q & ~rst;
  assign dbg_state = state_q;

`ifdef PIPE_STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             br_flush;

  assign br_flush = ~rst & br_taken_ex &
                    (((state_q == ST_RUN) & ~mc_op_ex) | (state_q == ST_LU));

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (br_flush && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
